// File: rtl/icache_port_arbiter.sv
// rtl/icache_port_arbiter.sv - I-cache port arbiter: demand/prefetch lookup and burst line refill
// Optional prefetch port arbitration is enabled by defining ICACHE_PREFETCH_EN.
module icache_port_arbiter #(
  parameter int WORDS_PER_LINE   = 16,
  parameter int LINE_OFFSET_BITS = 6,
  localparam int WW              = $clog2(WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          dmd_valid,
  input  logic [31:0]   dmd_addr,
  output logic          dmd_ready,
  input  logic          pf_valid,
  input  logic [31:0]   pf_addr,
  output logic          pf_ready,
  output logic          lookup_valid,
  output logic [31:0]   lookup_addr,
  input  logic          lookup_hit,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          refill_we,
  output logic [31:0]   refill_addr,
  output logic [WW-1:0] refill_word,
  output logic [31:0]   refill_data,
  output logic          resp_valid,
  output logic [31:0]   resp_addr,
  output logic [31:0]   miss_count,
  output logic [31:0]   pf_issue_count
);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESP} state_t;

`ifdef ICACHE_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{dmd_addr[LINE_OFFSET_BITS-1:0], pf_addr[LINE_OFFSET_BITS-1:0]};
`else
  localparam bit PF_EN = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{dmd_addr[LINE_OFFSET_BITS-1:0], pf_valid, pf_addr};
`endif

  localparam logic [WW-1:0] LAST_BEAT = WW'(WORDS_PER_LINE - 1);

  state_t        state, state_d;
  logic [31:0]   line_q;
  logic          src_q;
  logic          drop_q;
  logic [WW-1:0] beat_q;
  logic          accept_dmd, accept_pf, miss_inc, set_drop, beat_inc, beat_clr;
  logic          drop_now;

  // A flush seen in the current cycle counts as dropped immediately.
  assign drop_now    = drop_q | (flush & src_q);
  assign lookup_addr = line_q;
  assign mem_addr    = line_q;
  assign refill_addr = line_q;
  assign resp_addr   = line_q;
  assign refill_word = beat_q;
  assign refill_data = refill_we ? mem_rdata : 32'h0;

  always_comb begin
    state_d      = state;
    dmd_ready    = 1'b0;
    pf_ready     = 1'b0;
    lookup_valid = 1'b0;
    mem_req      = 1'b0;
    refill_we    = 1'b0;
    resp_valid   = 1'b0;
    accept_dmd   = 1'b0;
    accept_pf    = 1'b0;
    miss_inc     = 1'b0;
    set_drop     = 1'b0;
    beat_inc     = 1'b0;
    beat_clr     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          dmd_ready = !flush;
          pf_ready  = PF_EN && !dmd_valid && !flush;
          if (dmd_valid && !flush) begin
            accept_dmd = 1'b1;
            state_d    = LOOKUP;
          end else if (pf_valid && pf_ready) begin
            accept_pf = 1'b1;
            state_d   = LOOKUP;
          end
        end
        LOOKUP: begin
          lookup_valid = 1'b1;
          set_drop     = flush & src_q;
          if (lookup_hit) begin
            state_d = (src_q && !drop_now) ? RESP : IDLE;
          end else begin
            miss_inc = 1'b1;
            state_d  = REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          mem_req  = 1'b1;
          set_drop = flush & src_q;
          // Once acked, the burst must run to completion even under flush.
          if (mem_ack) begin
            beat_clr = 1'b1;
            state_d  = REFILL_DATA;
          end else if (flush) begin
            state_d = IDLE;
          end
        end
        REFILL_DATA: begin
          set_drop = flush & src_q;
          if (mem_rvalid) begin
            refill_we = 1'b1;
            beat_inc  = 1'b1;
            if (beat_q == LAST_BEAT)
              state_d = (src_q && !drop_now) ? RESP : IDLE;
          end
        end
        RESP: begin
          resp_valid = !flush;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      line_q         <= 32'h0;
      src_q          <= 1'b1;
      drop_q         <= 1'b0;
      beat_q         <= '0;
      miss_count     <= 32'h0;
      pf_issue_count <= 32'h0;
    end else begin
      state <= state_d;
      if (accept_dmd) begin
        line_q <= {dmd_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
        src_q  <= 1'b1;
      end
`ifdef ICACHE_PREFETCH_EN
      else if (accept_pf) begin
        line_q <= {pf_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
        src_q  <= 1'b0;
      end
      if (accept_pf)
        pf_issue_count <= pf_issue_count + 32'd1;
`endif
      if (state_d == IDLE)
        drop_q <= 1'b0;
      else if (set_drop)
        drop_q <= 1'b1;
      if (beat_clr)
        beat_q <= '0;
      else if (beat_inc)
        beat_q <= beat_q + 1'b1;
      if (miss_inc)
        miss_count <= miss_count + 32'd1;
    end
  end

endmodule
